// File: rtl/aud_pkg.sv
// -----------------------------------------------------------------------------
// aud_pkg
// Shared definitions for the audio record/playback path: default address and
// sample widths, the sequencer state encoding, and a small state helper.
// -----------------------------------------------------------------------------
package aud_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    // Encoding is visible on o_state for the front-panel display.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } aud_state_e;

    // The SRAM address follows the write pointer while a recording is open.
    function automatic logic is_rec_side(input aud_state_e s);
        return (s == ST_REC) || (s == ST_REC_PAUSE);
    endfunction

endpackage

// File: rtl/aud_rate_ctrl.sv
// -----------------------------------------------------------------------------
// aud_rate_ctrl
// Playback rate control. Given the current read address, computes the address
// to use after a playback tick and flags when that address runs past the last
// recorded sample. Owns the slow-mode repeat counter.
//
// Ports:
//   i_bclk, i_rst_n  clock, asynchronous active-low reset
//   tick             playback sample tick (only asserted in PLAY)
//   clear            restart playback: repeat counter back to zero
//   i_fast           1 = skip ahead by F per tick, 0 = repeat each sample F times
//   i_speed          speed factor minus one (F = i_speed + 1)
//   rd_addr          current read address
//   end_addr         address of the last recorded sample
//   next_addr        read address after this tick
//   end_flag         next address lies beyond end_addr
// -----------------------------------------------------------------------------
module aud_rate_ctrl #(
    parameter int ADDR_W = aud_pkg::ADDR_W
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              tick,
    input  logic              clear,
    input  logic              i_fast,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              end_flag
);

    logic [2:0]      rep_cnt;
    logic            advance;
    logic [ADDR_W:0] step;
    logic [ADDR_W:0] sum;

    // The sum carries one extra bit so a step past the top of memory is seen
    // as "past the end" rather than wrapping back to a low address.
    // '>=' keeps playback moving if i_speed is lowered below the current count.
    always_comb begin
        advance = (rep_cnt >= i_speed);
        step    = '0;
        if (i_fast) begin
            step = (ADDR_W+1)'(i_speed) + (ADDR_W+1)'(1);
        end else if (advance) begin
            step = (ADDR_W+1)'(1);
        end
        sum       = {1'b0, rd_addr} + step;
        next_addr = sum[ADDR_W-1:0];
        end_flag  = (sum > {1'b0, end_addr});
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt <= 3'd0;
        end else if (clear) begin
            rep_cnt <= 3'd0;
        end else if (tick) begin
            if (i_fast || advance) begin
                rep_cnt <= 3'd0;
            end else begin
                rep_cnt <= rep_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/aud_rec_play_ctrl.sv
// -----------------------------------------------------------------------------
// aud_rec_play_ctrl
// Record/playback sequencer. Turns key pulses into recorder start/stop,
// commits each new recorder sample to SRAM, replays stored samples to the
// player at a selectable speed, and multiplexes the single SRAM port.
//
// Ports:
//   i_bclk, i_rst_n          bit clock, asynchronous active-low reset
//   i_key_rec/play/pause/stop single-cycle key pulses (stop > pause > rec > play)
//   i_fast, i_speed          playback mode and speed factor (F = i_speed + 1)
//   i_lrc                    I2S LR clock; rising edge = playback tick
//   o_rec_start, o_rec_stop  one-cycle recorder control pulses
//   i_rec_addr, i_rec_data   recorder sample counter and sample
//   o_play_en, o_play_data   player enable and sample
//   o_sram_*, i_sram_rdata   SRAM port (asynchronous read)
//   o_state                  current state for display
//   o_done                   one-cycle pulse on record-full or playback end
//
// Handshake: a write is a single cycle with o_sram_we_n low; address and data
// are registered together and held for that whole cycle. A write captured in
// the same cycle as a key always completes, even if the key leaves REC.
// -----------------------------------------------------------------------------
module aud_rec_play_ctrl #(
    parameter int                ADDR_W   = aud_pkg::ADDR_W,
    parameter int                DATA_W   = aud_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic              i_fast,
    input  logic [2:0]        i_speed,
    input  logic              i_lrc,
    output logic              o_rec_start,
    output logic              o_rec_stop,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    output logic              o_play_en,
    output logic [DATA_W-1:0] o_play_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we_n,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [2:0]        o_state,
    output logic              o_done
);

    import aud_pkg::*;

    aud_state_e        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              has_data;
    logic [ADDR_W-1:0] rec_addr_q;
    logic              lrc_q;
    logic [ADDR_W-1:0] waddr_q;

    logic              capture;
    logic              tick;
    logic              clear;
    logic [ADDR_W-1:0] next_addr;
    logic              end_flag;

    // rec_addr_q follows i_rec_addr in every state, so increments seen while
    // paused or idle are simply absorbed and never turn into late writes.
    assign capture = (state == ST_REC) && (i_rec_addr != rec_addr_q);
    assign tick    = (state == ST_PLAY) && i_lrc && !lrc_q;
    assign clear   = (state == ST_IDLE) && !i_key_rec && i_key_play && has_data;

    assign o_state   = state;
    assign o_play_en = (state == ST_PLAY);

    // During a write strobe the latched write address wins so that the
    // address stays put even when the same edge changed state or wr_addr.
    assign o_sram_addr = !o_sram_we_n ? waddr_q
                       : (is_rec_side(state) ? wr_addr : rd_addr);

    aud_rate_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_rate (
        .i_bclk    (i_bclk),
        .i_rst_n   (i_rst_n),
        .tick      (tick),
        .clear     (clear),
        .i_fast    (i_fast),
        .i_speed   (i_speed),
        .rd_addr   (rd_addr),
        .end_addr  (end_addr),
        .next_addr (next_addr),
        .end_flag  (end_flag)
    );

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            wr_addr      <= '0;
            rd_addr      <= '0;
            end_addr     <= '0;
            has_data     <= 1'b0;
            rec_addr_q   <= '0;
            lrc_q        <= 1'b0;
            waddr_q      <= '0;
            o_sram_we_n  <= 1'b1;
            o_sram_wdata <= '0;
            o_play_data  <= '0;
            o_rec_start  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_rec_start <= 1'b0;
            o_rec_stop  <= 1'b0;
            o_done      <= 1'b0;
            o_sram_we_n <= 1'b1;
            rec_addr_q  <= i_rec_addr;
            lrc_q       <= i_lrc;

            case (state)
                ST_IDLE: begin
                    if (i_key_rec) begin
                        state       <= ST_REC;
                        wr_addr     <= '0;
                        has_data    <= 1'b0;
                        o_rec_start <= 1'b1;
                    end else if (i_key_play && has_data) begin
                        state   <= ST_PLAY;
                        rd_addr <= '0;
                    end
                end

                ST_REC: begin
                    if (capture) begin
                        o_sram_we_n  <= 1'b0;
                        waddr_q      <= wr_addr;
                        o_sram_wdata <= i_rec_data;
                        end_addr     <= wr_addr;
                        has_data     <= 1'b1;
                        wr_addr      <= wr_addr + ADDR_W'(1);
                    end
                    // A write into the last word ends the recording outright.
                    if (capture && (wr_addr == ADDR_MAX)) begin
                        state      <= ST_IDLE;
                        o_rec_stop <= 1'b1;
                        o_done     <= 1'b1;
                    end else if (i_key_stop) begin
                        state      <= ST_IDLE;
                        o_rec_stop <= 1'b1;
                    end else if (i_key_pause) begin
                        state <= ST_REC_PAUSE;
                    end
                end

                ST_REC_PAUSE: begin
                    if (i_key_stop) begin
                        state      <= ST_IDLE;
                        o_rec_stop <= 1'b1;
                    end else if (i_key_pause || i_key_rec) begin
                        state <= ST_REC;
                    end
                end

                ST_PLAY: begin
                    if (tick) begin
                        o_play_data <= i_sram_rdata;
                        if (!end_flag) begin
                            rd_addr <= next_addr;
                        end
                    end
                    // The final sample is still delivered on the ending tick.
                    if (tick && end_flag) begin
                        state  <= ST_IDLE;
                        o_done <= 1'b1;
                    end else if (i_key_stop) begin
                        state <= ST_IDLE;
                    end else if (i_key_pause) begin
                        state <= ST_PLAY_PAUSE;
                    end
                end

                ST_PLAY_PAUSE: begin
                    if (i_key_stop) begin
                        state <= ST_IDLE;
                    end else if (i_key_pause || i_key_play) begin
                        state <= ST_PLAY;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
